// File: rtl/calc_entrada_numero.sv
// calc_entrada_numero: digit-entry stage of the calculator.
// Assembles up to DIGITS BCD digits from keypad events into an operand and
// emits registered single-cycle events (operand ready, operator, igual) to
// the operation FSM.
// Optional feature: define CALC_ENTRADA_BACKSPACE_EN to make key 13 delete
// the last entered digit; otherwise key 13 is ignored like key 14.
module calc_entrada_numero #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic                  ingresar_numero_1_en,
  input  logic                  ingresar_numero_2_en,
  output logic [4*DIGITS-1:0]   operando,
  output logic                  operando_valid,
  output logic                  operando_en,
  output logic [3:0]            que_operacion,
  output logic                  igual_en,
  output logic [3:0]            n_digitos,
  output logic                  overflow
);

  localparam int         W        = 4 * DIGITS;
  localparam logic [3:0] DIGITS_C = 4'(DIGITS);

  localparam logic [1:0] VACIO    = 2'd0;
  localparam logic [1:0] CARGANDO = 2'd1;
  localparam logic [1:0] LLENO    = 2'd2;

  localparam logic [3:0] K_SUMA  = 4'd10;
  localparam logic [3:0] K_RESTA = 4'd11;
  localparam logic [3:0] K_CLEAR = 4'd12;
`ifdef CALC_ENTRADA_BACKSPACE_EN
  localparam logic [3:0] K_BACK  = 4'd13;
`endif
  localparam logic [3:0] K_IGUAL = 4'd15;

  logic [1:0]   state, state_n;
  // Set for the cycle in which a finished operand is presented; the register
  // is treated as empty from then on, so a key in the very next cycle lands
  // on a cleared operand while the presented value stays visible one cycle.
  logic         clear_pend, clear_pend_n;

  logic [W-1:0] base_op, op_n;
  logic [3:0]   base_cnt, cnt_n, cnt_inc;
  logic [1:0]   base_st;
  logic         ovf_n;
  logic [3:0]   que_n;
  logic         valid_n, oper_n, igual_n;
  logic         en_any;

  // Next-state and next-output computation for one sampled key event.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    base_op      = clear_pend ? '0    : operando;
    base_cnt     = clear_pend ? 4'd0  : n_digitos;
    base_st      = clear_pend ? VACIO : state;
    cnt_inc      = base_cnt + 4'd1;
    en_any       = ingresar_numero_1_en | ingresar_numero_2_en;

    op_n         = base_op;
    cnt_n        = base_cnt;
    state_n      = base_st;
    ovf_n        = overflow;
    que_n        = que_operacion;
    valid_n      = 1'b0;
    oper_n       = 1'b0;
    igual_n      = 1'b0;
    clear_pend_n = 1'b0;

    if (key_valid && en_any) begin
      case (key_code)
        K_SUMA, K_RESTA: begin
          if (ingresar_numero_1_en) begin
            valid_n      = 1'b1;
            oper_n       = 1'b1;
            que_n        = key_code;
            clear_pend_n = 1'b1;
          end
        end
        K_IGUAL: begin
          if (ingresar_numero_2_en) begin
            valid_n      = 1'b1;
            igual_n      = 1'b1;
            que_n        = key_code;
            clear_pend_n = 1'b1;
          end
        end
        K_CLEAR: begin
          op_n    = '0;
          cnt_n   = 4'd0;
          state_n = VACIO;
          ovf_n   = 1'b0;
        end
`ifdef CALC_ENTRADA_BACKSPACE_EN
        K_BACK: begin
          if (base_st != VACIO) begin
            op_n    = base_op >> 4;
            cnt_n   = base_cnt - 4'd1;
            state_n = (base_cnt == 4'd1) ? VACIO : CARGANDO;
          end
        end
`endif
        default: begin
          // Digits 0-9; code 14 (and 13 without backspace) falls through idle.
          if (key_code <= 4'd9) begin
            case (base_st)
              VACIO: begin
                // A leading zero leaves the empty operand untouched.
                if (key_code != 4'd0) begin
                  op_n    = W'(key_code);
                  cnt_n   = 4'd1;
                  state_n = (DIGITS_C == 4'd1) ? LLENO : CARGANDO;
                end
              end
              CARGANDO: begin
                op_n    = {base_op[W-5:0], key_code};
                cnt_n   = cnt_inc;
                state_n = (cnt_inc == DIGITS_C) ? LLENO : CARGANDO;
              end
              default: ovf_n = 1'b1;
            endcase
          end
        end
      endcase
    end
  end

  // Register all state and outputs; synchronous reset dominates key events.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state          <= VACIO;
      clear_pend     <= 1'b0;
      operando       <= '0;
      n_digitos      <= 4'd0;
      overflow       <= 1'b0;
      que_operacion  <= 4'd0;
      operando_valid <= 1'b0;
      operando_en    <= 1'b0;
      igual_en       <= 1'b0;
    end else begin
      state          <= state_n;
      clear_pend     <= clear_pend_n;
      operando       <= op_n;
      n_digitos      <= cnt_n;
      overflow       <= ovf_n;
      que_operacion  <= que_n;
      operando_valid <= valid_n;
      operando_en    <= oper_n;
      igual_en       <= igual_n;
    end
  end

endmodule

// File: tb/tb_calc_entrada_numero.sv
// Directed self-checking bench for calc_entrada_numero (DIGITS = 4).
// Inputs change on the falling edge; outputs are checked on the falling edge
// after the rising edge that sampled the key.
module tb_calc_entrada_numero;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        ingresar_numero_1_en;
  logic        ingresar_numero_2_en;
  logic [15:0] operando;
  logic        operando_valid;
  logic        operando_en;
  logic [3:0]  que_operacion;
  logic        igual_en;
  logic [3:0]  n_digitos;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  calc_entrada_numero #(.DIGITS(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .key_valid            (key_valid),
    .key_code             (key_code),
    .ingresar_numero_1_en (ingresar_numero_1_en),
    .ingresar_numero_2_en (ingresar_numero_2_en),
    .operando             (operando),
    .operando_valid       (operando_valid),
    .operando_en          (operando_en),
    .que_operacion        (que_operacion),
    .igual_en             (igual_en),
    .n_digitos            (n_digitos),
    .overflow             (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Check every output in one go.
  task automatic check_all(input string tag, input logic [15:0] op,
                           input logic [3:0] n, input logic ovf,
                           input logic [3:0] que, input logic val,
                           input logic oen, input logic ien);
    check({tag, ".operando"},       32'(operando),       32'(op));
    check({tag, ".n_digitos"},      32'(n_digitos),      32'(n));
    check({tag, ".overflow"},       32'(overflow),       32'(ovf));
    check({tag, ".que_operacion"},  32'(que_operacion),  32'(que));
    check({tag, ".operando_valid"}, 32'(operando_valid), 32'(val));
    check({tag, ".operando_en"},    32'(operando_en),    32'(oen));
    check({tag, ".igual_en"},       32'(igual_en),       32'(ien));
  endtask

  // One-cycle key pulse; returns at the falling edge where its result shows.
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    key_valid = 1'b0;
    key_code = 4'd0;
    ingresar_numero_1_en = 1'b0;
    ingresar_numero_2_en = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset", 16'h0000, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Plain digit entry.
    ingresar_numero_1_en = 1'b1;
    press(4'd1); press(4'd2); press(4'd3);
    check_all("d123", 16'h0123, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Leading zeros, then operator.
    press(4'd12);
    check_all("clear1", 16'h0000, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    press(4'd0);
    check_all("lead0a", 16'h0000, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    press(4'd0);
    check_all("lead0b", 16'h0000, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    press(4'd7);
    check_all("d7", 16'h0007, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    press(4'd10);
    check_all("suma_pulse", 16'h0007, 4'd1, 1'b0, 4'd10, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_all("suma_after", 16'h0000, 4'd0, 1'b0, 4'd10, 1'b0, 1'b0, 1'b0);

    // Fill the register and overflow.
    press(4'd9); press(4'd8); press(4'd7); press(4'd6);
    check_all("full", 16'h9876, 4'd4, 1'b0, 4'd10, 1'b0, 1'b0, 1'b0);
    press(4'd5);
    check_all("ovf", 16'h9876, 4'd4, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0);
    press(4'd12);
    check_all("clear2", 16'h0000, 4'd0, 1'b0, 4'd10, 1'b0, 1'b0, 1'b0);

    // Second-operand entry: operator ignored, igual accepted.
    ingresar_numero_1_en = 1'b0;
    ingresar_numero_2_en = 1'b1;
    press(4'd4);
    check_all("op2_d4", 16'h0004, 4'd1, 1'b0, 4'd10, 1'b0, 1'b0, 1'b0);
    press(4'd11);
    check_all("op2_resta_ign", 16'h0004, 4'd1, 1'b0, 4'd10, 1'b0, 1'b0, 1'b0);
    press(4'd15);
    check_all("igual_pulse", 16'h0004, 4'd1, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check_all("igual_after", 16'h0000, 4'd0, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);

    // Igual ignored when only the first enable is active.
    ingresar_numero_1_en = 1'b1;
    ingresar_numero_2_en = 1'b0;
    press(4'd3);
    press(4'd15);
    check_all("igual_ign", 16'h0003, 4'd1, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);

    // No enable: nothing changes.
    ingresar_numero_1_en = 1'b0;
    press(4'd5);
    check_all("noen_d5", 16'h0003, 4'd1, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);
    press(4'd10);
    check_all("noen_suma", 16'h0003, 4'd1, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);
    press(4'd15);
    check_all("noen_igual", 16'h0003, 4'd1, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);
    press(4'd12);
    check_all("noen_clear", 16'h0003, 4'd1, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);

    // Back-to-back: resta then a digit in the very next cycle.
    ingresar_numero_1_en = 1'b1;
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'd11;
    @(negedge clk);
    check_all("b2b_resta", 16'h0003, 4'd1, 1'b0, 4'd11, 1'b1, 1'b1, 1'b0);
    key_code  = 4'd5;
    @(negedge clk);
    key_valid = 1'b0;
    check_all("b2b_d5", 16'h0005, 4'd1, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0);

    // Empty entry with an operator yields operand 0.
    press(4'd12);
    press(4'd10);
    check_all("empty_suma", 16'h0000, 4'd0, 1'b0, 4'd10, 1'b1, 1'b1, 1'b0);

    // Key 14 ignored.
    press(4'd6);
    press(4'd14);
    check_all("key14", 16'h0006, 4'd1, 1'b0, 4'd10, 1'b0, 1'b0, 1'b0);

    // Reset dominates a simultaneous key mid-entry.
    press(4'd12); press(4'd1); press(4'd2);
    check_all("pre_reset", 16'h0012, 4'd2, 1'b0, 4'd10, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset     = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'd3;
    @(negedge clk);
    reset     = 1'b0;
    key_valid = 1'b0;
    check_all("reset_mid", 16'h0000, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Backspace (key 13).
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    check_all("bs_full", 16'h1234, 4'd4, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    press(4'd13);
`ifdef CALC_ENTRADA_BACKSPACE_EN
    check_all("bs_del", 16'h0123, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    press(4'd5);
    check_all("bs_d5", 16'h1235, 4'd4, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
`else
    check_all("bs_ign", 16'h1234, 4'd4, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    press(4'd5);
    check_all("bs_ovf", 16'h1234, 4'd4, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
